// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths and requester IDs.
package regfile_pkg;

    localparam int unsigned DBITS_DEF = 32;
    localparam int unsigned ABITS_DEF = 4;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus carrying both requesters (ALU = req0, memory load = req1).
interface regfile_wb_arbiter_if #(
    parameter int unsigned DBITS = regfile_pkg::DBITS_DEF,
    parameter int unsigned ABITS = regfile_pkg::ABITS_DEF
);
    logic             req0_valid;
    logic             req0_ready;
    logic [ABITS-1:0] req0_ind;
    logic [DBITS-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [ABITS-1:0] req1_ind;
    logic [DBITS-1:0] req1_data;

    modport master (
        output req0_valid, req0_ind, req0_data,
        output req1_valid, req1_ind, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_ind, req0_data,
        input  req1_valid, req1_ind, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational, pointer moves on transfer.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_valid_i,
    input  logic req1_valid_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!rst_i) begin
            gnt0_o = req0_valid_i && (!req1_valid_i || last_q == REQ_MEM);
            gnt1_o = req1_valid_i && (!req0_valid_i || last_q == REQ_ALU);
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0_o)      last_d = REQ_ALU;
        else if (gnt1_o) last_d = REQ_MEM;
    end

    // Reset to "req1 last" so req0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= REQ_MEM;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter with busy scoreboard and registered register-file write port.
// Optional WB_BYPASS_EN adds rdHit/rdByp forwarding outputs.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DBITS = DBITS_DEF,
    parameter int unsigned ABITS = ABITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    regfile_wb_arbiter_if.slave bus,
    output logic             wrtEn,
    output logic [ABITS-1:0] wrtInd,
    output logic [DBITS-1:0] dIn,
    input  logic             issue_en,
    input  logic [ABITS-1:0] issue_ind,
    input  logic [ABITS-1:0] rdInd0,
    input  logic [ABITS-1:0] rdInd1,
    output logic             rdBusy0,
    output logic             rdBusy1
`ifdef WB_BYPASS_EN
    ,
    output logic             rdHit0,
    output logic             rdHit1,
    output logic [DBITS-1:0] rdByp0,
    output logic [DBITS-1:0] rdByp1
`endif
);
    localparam int unsigned NREG = 1 << ABITS;

    logic             gnt0;
    logic             gnt1;
    logic             wrt_en_q,  wrt_en_d;
    logic [ABITS-1:0] wrt_ind_q, wrt_ind_d;
    logic [DBITS-1:0] din_q,     din_d;
    logic [NREG-1:0]  busy_q,    busy_d;

    rr_arb2 u_arb (
        .clk_i        (clk),
        .rst_i        (reset),
        .req0_valid_i (bus.req0_valid),
        .req1_valid_i (bus.req1_valid),
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1)
    );

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    always_comb begin
        wrt_en_d  = gnt0 || gnt1;
        wrt_ind_d = wrt_ind_q;
        din_d     = din_q;
        busy_d    = busy_q;
        if (gnt0) begin
            wrt_ind_d             = bus.req0_ind;
            din_d                 = bus.req0_data;
            busy_d[bus.req0_ind]  = 1'b0;
        end else if (gnt1) begin
            wrt_ind_d             = bus.req1_ind;
            din_d                 = bus.req1_data;
            busy_d[bus.req1_ind]  = 1'b0;
        end
        // Applied after the clear so a same-index issue keeps the bit set.
        if (issue_en) busy_d[issue_ind] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrt_en_q  <= 1'b0;
            wrt_ind_q <= '0;
            din_q     <= '0;
            busy_q    <= '0;
        end else begin
            wrt_en_q  <= wrt_en_d;
            wrt_ind_q <= wrt_ind_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
        end
    end

    assign wrtEn   = wrt_en_q;
    assign wrtInd  = wrt_ind_q;
    assign dIn     = din_q;
    assign rdBusy0 = busy_q[rdInd0];
    assign rdBusy1 = busy_q[rdInd1];

`ifdef WB_BYPASS_EN
    assign rdHit0 = wrt_en_q && (wrt_ind_q == rdInd0);
    assign rdHit1 = wrt_en_q && (wrt_ind_q == rdInd1);
    assign rdByp0 = rdHit0 ? din_q : '0;
    assign rdByp1 = rdHit1 ? din_q : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (directed scenarios plus randomized run).
module tb_regfile_wb_arbiter;
    localparam int unsigned DB = 32;
    localparam int unsigned AB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_en;
    logic [AB-1:0] issue_ind, rdInd0, rdInd1;
    logic          wrtEn, rdBusy0, rdBusy1;
    logic [AB-1:0] wrtInd;
    logic [DB-1:0] dIn;
`ifdef WB_BYPASS_EN
    logic          rdHit0, rdHit1;
    logic [DB-1:0] rdByp0, rdByp1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: write-port contents, busy set, who won most recently.
    logic          m_wen;
    logic [AB-1:0] m_ind;
    logic [DB-1:0] m_data;
    bit   [15:0]   m_busy;
    int            m_last;

    regfile_wb_arbiter_if #(.DBITS(DB), .ABITS(AB)) bus ();

    regfile_wb_arbiter #(.DBITS(DB), .ABITS(AB)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .wrtEn     (wrtEn),
        .wrtInd    (wrtInd),
        .dIn       (dIn),
        .issue_en  (issue_en),
        .issue_ind (issue_ind),
        .rdInd0    (rdInd0),
        .rdInd1    (rdInd1),
        .rdBusy0   (rdBusy0),
        .rdBusy1   (rdBusy1)
`ifdef WB_BYPASS_EN
        ,
        .rdHit0    (rdHit0),
        .rdHit1    (rdHit1),
        .rdByp0    (rdByp0),
        .rdByp1    (rdByp1)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_grant(input logic v0, input logic v1);
        if (v0 && v1) return (m_last == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_wen  = 1'b0;
        m_ind  = '0;
        m_data = '0;
        m_busy = '0;
        m_last = 1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        issue_en       = 1'b0;
    endtask

    // Advance one clock and apply the requester/scoreboard rules to the model.
    task automatic tick();
        int            g;
        logic [AB-1:0] i0, i1, ii;
        logic [DB-1:0] d0, d1;
        logic          ie;
        g  = model_grant(bus.req0_valid, bus.req1_valid);
        i0 = bus.req0_ind;  d0 = bus.req0_data;
        i1 = bus.req1_ind;  d1 = bus.req1_data;
        ie = issue_en;      ii = issue_ind;
        @(posedge clk);
        m_wen = (g >= 0);
        if (g == 0) begin
            m_ind = i0; m_data = d0; m_busy[i0] = 1'b0; m_last = 0;
        end else if (g == 1) begin
            m_ind = i1; m_data = d1; m_busy[i1] = 1'b0; m_last = 1;
        end
        if (ie) m_busy[ii] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
        end
        n_cmp++;
        if ({wrtEn, wrtInd, dIn} !== '0) begin
            n_bad++; $display("FAIL reset_wport: got en=%b ind=%0d d=%h want 0/0/0", wrtEn, wrtInd, dIn);
        end
        n_cmp++;
        if ({rdBusy0, rdBusy1} !== 2'b00) begin
            n_bad++; $display("FAIL reset_busy: got %b want 00", {rdBusy0, rdBusy1});
        end
        idle_inputs();
        #1 reset = 1'b0;
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1; bus.req0_ind = 4'd3; bus.req0_data = 32'hAAAA5555;
        #1;
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0;
        n_cmp++;
        if ({wrtEn, wrtInd, dIn} !== {1'b1, 4'd3, 32'hAAAA5555}) begin
            n_bad++; $display("FAIL single_write: got en=%b ind=%0d d=%h want 1/3/aaaa5555", wrtEn, wrtInd, dIn);
        end
        tick();
        n_cmp++;
        if ({wrtEn, wrtInd, dIn} !== {1'b0, 4'd3, 32'hAAAA5555}) begin
            n_bad++; $display("FAIL single_hold: got en=%b ind=%0d d=%h want 0/3/aaaa5555", wrtEn, wrtInd, dIn);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_ind = 4'd1; bus.req0_data = 32'h0000_0A10;
        bus.req1_valid = 1'b1; bus.req1_ind = 4'd2; bus.req1_data = 32'h0000_0B20;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i,
                                  {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                n_cmp++;
                if (wrtEn !== 1'b1) begin
                    n_bad++; $display("FAIL rr_wren[%0d]: got %b want 1", i, wrtEn);
                end
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if ({wrtEn, wrtInd} !== {1'b1, 4'd2}) begin
            n_bad++; $display("FAIL rr_last: got en=%b ind=%0d want 1/2", wrtEn, wrtInd);
        end
        tick();
        n_cmp++;
        if (wrtEn !== 1'b0) begin
            n_bad++; $display("FAIL rr_drain: got %b want 0", wrtEn);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_ind = 4'd5;
        tick();
        issue_en = 1'b0; rdInd0 = 4'd5;
        #1;
        n_cmp++;
        if (rdBusy0 !== 1'b1) begin
            n_bad++; $display("FAIL sb_set: got %b want 1", rdBusy0);
        end
        bus.req1_valid = 1'b1; bus.req1_ind = 4'd5; bus.req1_data = 32'h5555_0005;
        #1;
        n_cmp++;
        if ({bus.req1_ready, rdBusy0} !== 2'b11) begin
            n_bad++; $display("FAIL sb_accept: got ready/busy=%b want 11", {bus.req1_ready, rdBusy0});
        end
        tick();
        bus.req1_valid = 1'b0;
        n_cmp++;
        if (rdBusy0 !== 1'b0) begin
            n_bad++; $display("FAIL sb_clear: got %b want 0", rdBusy0);
        end
    endtask

    task automatic test_set_wins();
        issue_en = 1'b1; issue_ind = 4'd7;
        bus.req0_valid = 1'b1; bus.req0_ind = 4'd7; bus.req0_data = 32'h7777_0007;
        tick();
        idle_inputs();
        rdInd1 = 4'd7;
        #1;
        n_cmp++;
        if ({rdBusy1, wrtEn, wrtInd} !== {1'b1, 1'b1, 4'd7}) begin
            n_bad++; $display("FAIL set_wins: got busy=%b en=%b ind=%0d want 1/1/7", rdBusy1, wrtEn, wrtInd);
        end
    endtask

    task automatic test_async_reset();
        bus.req0_valid = 1'b1; bus.req0_ind = 4'd9; bus.req0_data = 32'h9999_0009;
        tick();
        idle_inputs();
        rdInd0 = 4'd7; rdInd1 = 4'd7;
        #1;
        n_cmp++;
        if ({wrtEn, rdBusy1} !== 2'b11) begin
            n_bad++; $display("FAIL areset_pre: got en/busy=%b want 11", {wrtEn, rdBusy1});
        end
        #1 reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({wrtEn, rdBusy0, rdBusy1} !== 3'b000) begin
            n_bad++; $display("FAIL areset_now: got en/b0/b1=%b want 000", {wrtEn, rdBusy0, rdBusy1});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (wrtEn !== 1'b0) begin
                n_bad++; $display("FAIL areset_nopulse[%0d]: got %b want 0", i, wrtEn);
            end
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        bus.req1_valid = 1'b1; bus.req1_ind = 4'd2; bus.req1_data = 32'h0000_1234;
        tick();
        idle_inputs();
        rdInd1 = 4'd2;
        #1;
        n_cmp++;
        if ({rdHit1, rdByp1} !== {1'b1, 32'h0000_1234}) begin
            n_bad++; $display("FAIL byp_hit: got hit=%b byp=%h want 1/00001234", rdHit1, rdByp1);
        end
        rdInd1 = 4'd4;
        #1;
        n_cmp++;
        if ({rdHit1, rdByp1} !== {1'b0, 32'h0}) begin
            n_bad++; $display("FAIL byp_miss: got hit=%b byp=%h want 0/0", rdHit1, rdByp1);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        int g;
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req0_ind   = 4'($urandom_range(0, 15));
            bus.req1_ind   = ($urandom_range(0, 3) == 0) ? bus.req0_ind : 4'($urandom_range(0, 15));
            bus.req0_data  = $urandom;
            bus.req1_data  = $urandom;
            issue_en       = ($urandom_range(0, 1) == 1);
            issue_ind      = 4'($urandom_range(0, 15));
            rdInd0         = 4'($urandom_range(0, 15));
            rdInd1         = 4'($urandom_range(0, 15));
            #1;
            g = model_grant(bus.req0_valid, bus.req1_valid);
            n_cmp++;
            if ({bus.req0_ready, bus.req1_ready} !== {g == 0, g == 1}) begin
                n_bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", i,
                                  {bus.req0_ready, bus.req1_ready}, {g == 0, g == 1});
            end
            n_cmp++;
            if ({wrtEn, wrtInd, dIn} !== {m_wen, m_ind, m_data}) begin
                n_bad++; $display("FAIL rnd_wport[%0d]: got %b/%0d/%h want %b/%0d/%h", i,
                                  wrtEn, wrtInd, dIn, m_wen, m_ind, m_data);
            end
            n_cmp++;
            if ({rdBusy0, rdBusy1} !== {m_busy[rdInd0], m_busy[rdInd1]}) begin
                n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i,
                                  {rdBusy0, rdBusy1}, {m_busy[rdInd0], m_busy[rdInd1]});
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.req0_ind = '0; bus.req0_data = '0;
        bus.req1_ind = '0; bus.req1_data = '0;
        issue_ind = '0; rdInd0 = '0; rdInd1 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_set_wins();
        test_async_reset();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
